button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter WIDTH, default 4: number of independent button channels, range 1..32.
REQ-002 Parameter DEBOUNCE_LIMIT, default 1_000_000: required consecutive stable cycles (20 ms at 50 MHz), range 1..2^24-1.
REQ-003 Parameter REPEAT_DELAY, default 25_000_000: cycles from press to first auto-repeat (500 ms); 0 disables auto-repeat.
REQ-004 Parameter REPEAT_RATE, default 5_000_000: cycles between subsequent auto-repeats (100 ms), range 1..2^26-1.
REQ-005 Parameter ACTIVE_LOW, default 0: 1 = raw input low means pressed; raw input is inverted before synchronisation.
REQ-006 clk  input  1  system clock, 50 MHz, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 raw_signal  input  WIDTH  asynchronous raw button inputs.
REQ-009 debounced_signal  output  WIDTH  clean level per channel, 1 = pressed.
REQ-010 press_pulse  output  WIDTH  one-cycle strobe on debounced rising transition.
REQ-011 release_pulse  output  WIDTH  one-cycle strobe on debounced falling transition.
REQ-012 repeat_pulse  output  WIDTH  one-cycle strobe on press, then at auto-repeat instants while held.

Function
REQ-013 Each channel SHALL be fully independent: 2-flop synchroniser, debounce counter, hold counter, 3-state FSM; no shared counters.
REQ-014 Synchroniser output s SHALL equal (raw XOR ACTIVE_LOW) delayed by 2 clocks.
REQ-015 Debounce counter SHALL increment each cycle s != debounced and clear to 0 any cycle s == debounced.
REQ-016 On the cycle s != debounced with counter == DEBOUNCE_LIMIT-1, debounced SHALL take s and counter SHALL clear; raw-edge-to-debounced latency = 2 + DEBOUNCE_LIMIT cycles.
REQ-017 A mismatch lasting fewer than DEBOUNCE_LIMIT consecutive cycles SHALL produce no output change.
REQ-018 press_pulse/release_pulse SHALL be registered and high exactly during the first cycle debounced shows the new level.
REQ-019 FSM states: IDLE (released), DELAY (held, waiting REPEAT_DELAY), REPEAT (held, repeating every REPEAT_RATE).
REQ-020 IDLE -> DELAY on debounced rise: repeat_pulse high same cycle as press_pulse, hold counter cleared to 0.
REQ-021 In DELAY, hold counter increments per cycle; when it reaches REPEAT_DELAY-1, next cycle repeat_pulse asserts, counter clears, state -> REPEAT (first repeat REPEAT_DELAY cycles after press pulse).
REQ-022 In REPEAT, repeat_pulse asserts every REPEAT_RATE cycles, counter clearing on each pulse.
REQ-023 REPEAT_DELAY == 0: DELAY SHALL be held indefinitely, only the press-time repeat_pulse occurs.
REQ-024 Any state -> IDLE on debounced fall; release has priority: no repeat_pulse in the release_pulse cycle even if a repeat was due.
REQ-025 Counters SHALL be sized by $clog2 of their limit plus 1 bit and never wrap within a phase.
REQ-026 Simultaneous events on different channels SHALL produce simultaneous pulses with no arbitration.

Reset
REQ-027 rst high SHALL asynchronously clear synchronisers (to the released level), all counters, debounced_signal, all pulses, FSM to IDLE.
REQ-028 Reset asserted mid-debounce or mid-repeat SHALL abort it without any pulse; after rst deasserts, a still-held button SHALL produce press_pulse 2+DEBOUNCE_LIMIT cycles later.

Verification (DEBOUNCE_LIMIT=4, REPEAT_DELAY=10, REPEAT_RATE=3, WIDTH=4)
REQ-029 raw[0] 0->1 held -> debounced[0]=1 and press_pulse[0]=repeat_pulse[0]=1 for 1 cycle at cycle 6 after edge; other channels stay 0.
REQ-030 raw[1] 3-cycle high glitch -> no change on any output of channel 1.
REQ-031 raw[2] held 30 cycles after press pulse -> repeat_pulse[2] at offsets 0, 10, 13, 16, 19, 22, 25, 28.
REQ-032 raw[3] released exactly when a repeat is due -> release_pulse[3]=1, repeat_pulse[3]=0 that cycle, FSM IDLE.
REQ-033 ACTIVE_LOW=1, raw idle 4'hF, raw[0] driven 0 -> press_pulse[0] after 6 cycles; reset mid-DELAY -> all outputs 0 immediately, press_pulse re-fires 6 cycles after rst release.
REQ-034 All channels pressed same cycle -> press_pulse=4'hF for exactly one cycle.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Per-channel push-button conditioning: each channel runs its own two-flop
// synchroniser, debounce counter, hold counter and three-state repeat FSM.
// No counter or state is shared between channels, so simultaneous events on
// several channels produce simultaneous pulses.
//
// Parameters
//   WIDTH           number of independent button channels (1..32)
//   DEBOUNCE_LIMIT  consecutive cycles a new level must persist before it is
//                   accepted (1..2^24-1)
//   REPEAT_DELAY    cycles from the press pulse to the first auto-repeat;
//                   0 disables auto-repeat
//   REPEAT_RATE     cycles between subsequent auto-repeats (1..2^26-1)
//   ACTIVE_LOW      1 = a low raw input means pressed
//
// Ports
//   clk               system clock, all state updates on the rising edge
//   rst               asynchronous active-high reset
//   raw_signal        raw, asynchronous button inputs
//   debounced_signal  clean level per channel, 1 = pressed
//   press_pulse       one-cycle strobe in the first cycle debounced shows 1
//   release_pulse     one-cycle strobe in the first cycle debounced shows 0
//   repeat_pulse      one-cycle strobe at the press and at each auto-repeat
//
// Handshake: none. All outputs are registered levels/strobes, valid every
// cycle; strobes are high for exactly one clock and need no acknowledge.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 1_000_000,
  parameter int unsigned REPEAT_DELAY   = 25_000_000,
  parameter int unsigned REPEAT_RATE    = 5_000_000,
  parameter bit          ACTIVE_LOW     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] repeat_pulse
);

  // ---------------------------------------------------------------------------
  // Counter sizing. Each counter gets one bit of headroom above its limit so
  // it can never wrap inside a phase.
  // ---------------------------------------------------------------------------
  localparam int unsigned DB_W       = $clog2(DEBOUNCE_LIMIT) + 1;
  localparam int unsigned HOLD_LIMIT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                                    : REPEAT_RATE;
  localparam int unsigned HOLD_W     = $clog2(HOLD_LIMIT) + 1;

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [DB_W-1:0]   DB_ONE     = DB_W'(1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
  localparam bit                REPEAT_EN  = (REPEAT_DELAY != 0);

  // Repeat FSM encoding, one instance per channel.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // released
    ST_DELAY  = 2'd1,  // held, waiting for the first auto-repeat
    ST_REPEAT = 2'd2   // held, repeating at REPEAT_RATE
  } chan_state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser. The polarity flip happens before the first flop so that the
  // whole channel works in "1 = pressed" terms and reset (all zeros) is the
  // released level regardless of ACTIVE_LOW.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= raw_signal ^ {WIDTH{ACTIVE_LOW}};
      sync_s    <= sync_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce and repeat logic.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    logic [DB_W-1:0]   db_cnt_q;
    logic              deb_q;
    logic              press_q;
    logic              release_q;
    logic              settle;
    logic              rise;
    logic              fall;

    chan_state_e       fsm_state_q;
    chan_state_e       fsm_state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              repeat_q;
    logic              repeat_d;

    // settle is high on the edge where the debounced level flips: the input
    // has disagreed for DEBOUNCE_LIMIT-1 cycles already and still disagrees.
    assign settle = (sync_s[g] != deb_q) && (db_cnt_q == DB_LAST);
    assign rise   = settle &  sync_s[g];
    assign fall   = settle & ~sync_s[g];

    // Debounce counter and edge strobes. The strobes are registered from the
    // same condition that updates deb_q, so they line up with the first
    // cycle the new level is visible.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt_q  <= '0;
        deb_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= rise;
        release_q <= fall;
        if (sync_s[g] != deb_q) begin
          if (db_cnt_q == DB_LAST) begin
            deb_q    <= sync_s[g];
            db_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + DB_ONE;
          end
        end else begin
          db_cnt_q <= '0;
        end
      end
    end

    // Repeat FSM state register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fsm_state_q <= ST_IDLE;
        hold_cnt_q  <= '0;
        repeat_q    <= 1'b0;
      end else begin
        fsm_state_q <= fsm_state_d;
        hold_cnt_q  <= hold_cnt_d;
        repeat_q    <= repeat_d;
      end
    end

    // Repeat FSM next-state logic. A debounced fall is checked first so a
    // repeat that happens to fall due on the release edge is suppressed.
    always_comb begin
      fsm_state_d = fsm_state_q;
      hold_cnt_d  = hold_cnt_q;
      repeat_d    = 1'b0;
      if (fall) begin
        fsm_state_d = ST_IDLE;
        hold_cnt_d  = '0;
      end else if (rise) begin
        fsm_state_d = ST_DELAY;
        hold_cnt_d  = '0;
        repeat_d    = 1'b1;
      end else begin
        case (fsm_state_q)
          ST_IDLE: begin
            hold_cnt_d = '0;
          end
          ST_DELAY: begin
            // With auto-repeat disabled the channel parks here until release
            // and the hold counter stays at zero.
            if (REPEAT_EN) begin
              if (hold_cnt_q == DELAY_LAST) begin
                fsm_state_d = ST_REPEAT;
                hold_cnt_d  = '0;
                repeat_d    = 1'b1;
              end else begin
                hold_cnt_d = hold_cnt_q + HOLD_ONE;
              end
            end
          end
          ST_REPEAT: begin
            if (hold_cnt_q == RATE_LAST) begin
              hold_cnt_d = '0;
              repeat_d   = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
          end
          default: begin
            fsm_state_d = ST_IDLE;
            hold_cnt_d  = '0;
          end
        endcase
      end
    end

    assign debounced_signal[g] = deb_q;
    assign press_pulse[g]      = press_q;
    assign release_pulse[g]    = release_q;
    assign repeat_pulse[g]     = repeat_q;
  end : g_chan

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Three instances of button_conditioner share one stimulus:
//   a_*  active-high inputs, auto-repeat enabled
//   b_*  active-low inputs fed with the inverted stimulus (same expectations)
//   n_*  active-high inputs, auto-repeat disabled (REPEAT_DELAY = 0)
// A behavioural model predicts every output each cycle from the raw history,
// and directed sequences pin the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_button_conditioner;
  localparam int W  = 4;
  localparam int DL = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw = '0;
  logic [W-1:0] raw_al;
  logic [W-1:0] a_deb, a_press, a_rel, a_rep;
  logic [W-1:0] b_deb, b_press, b_rel, b_rep;
  logic [W-1:0] n_deb, n_press, n_rel, n_rep;

  assign raw_al = ~raw;

  always #5 clk = ~clk;

  button_conditioner #(.WIDTH(W), .DEBOUNCE_LIMIT(DL), .REPEAT_DELAY(RD),
                       .REPEAT_RATE(RR), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .raw_signal(raw),
    .debounced_signal(a_deb), .press_pulse(a_press),
    .release_pulse(a_rel), .repeat_pulse(a_rep));

  button_conditioner #(.WIDTH(W), .DEBOUNCE_LIMIT(DL), .REPEAT_DELAY(RD),
                       .REPEAT_RATE(RR), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .raw_signal(raw_al),
    .debounced_signal(b_deb), .press_pulse(b_press),
    .release_pulse(b_rel), .repeat_pulse(b_rep));

  button_conditioner #(.WIDTH(W), .DEBOUNCE_LIMIT(DL), .REPEAT_DELAY(0),
                       .REPEAT_RATE(RR), .ACTIVE_LOW(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .raw_signal(raw),
    .debounced_signal(n_deb), .press_pulse(n_press),
    .release_pulse(n_rel), .repeat_pulse(n_rep));

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model.
  // raw_q keeps the last DL+2 raw samples. The synchronised value seen at an
  // edge is the raw value from two edges earlier, so the oldest DL entries are
  // the synchronised values of the last DL edges. A channel's clean level
  // flips once all DL of those disagree with it. Repeats are pure arithmetic
  // on the cycle distance from the press.
  // ---------------------------------------------------------------------------
  logic [W-1:0] raw_q[$];
  logic [W-1:0] m_deb, m_press, m_rel, m_rep, m_rep0;
  int           press_t[W];
  int           cyc = 0;

  task automatic model_step();
    logic [W-1:0] v;
    logic         flip;
    int           k;
    cyc++;
    m_press = '0;
    m_rel   = '0;
    m_rep   = '0;
    m_rep0  = '0;
    if (rst) begin
      raw_q.delete();
      for (int i = 0; i < DL + 2; i++) raw_q.push_back('0);
      m_deb = '0;
    end else begin
      raw_q.push_back(raw);
      void'(raw_q.pop_front());
      for (int c = 0; c < W; c++) begin
        flip = 1'b1;
        for (int i = 0; i < DL; i++) begin
          v = raw_q[i];
          if (v[c] == m_deb[c]) flip = 1'b0;
        end
        if (flip) begin
          m_deb[c] = ~m_deb[c];
          if (m_deb[c]) begin
            m_press[c] = 1'b1;
            press_t[c] = cyc;
          end else begin
            m_rel[c] = 1'b1;
          end
        end
        if (m_deb[c]) begin
          k = cyc - press_t[c];
          m_rep[c]  = (k == 0) || (k >= RD && ((k - RD) % RR) == 0);
          m_rep0[c] = (k == 0);
        end
      end
    end
  endtask

  // Cycle compare: model advances on each rising edge, DUTs are sampled 1ns later.
  always @(posedge clk) begin
    model_step();
    #1;
    check("a_deb",   a_deb,   m_deb);
    check("a_press", a_press, m_press);
    check("a_rel",   a_rel,   m_rel);
    check("a_rep",   a_rep,   m_rep);
    check("b_deb",   b_deb,   m_deb);
    check("b_press", b_press, m_press);
    check("b_rel",   b_rel,   m_rel);
    check("b_rep",   b_rep,   m_rep);
    check("n_deb",   n_deb,   m_deb);
    check("n_press", n_press, m_press);
    check("n_rel",   n_rel,   m_rel);
    check("n_rep",   n_rep,   m_rep0);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_a"}, {a_deb, a_press, a_rel, a_rep}, 32'h0);
    check({name, "_b"}, {b_deb, b_press, b_rel, b_rep}, 32'h0);
    check({name, "_n"}, {n_deb, n_press, n_rel, n_rep}, 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] acc;
    int           offs[$];
    int           noffs;
    int           exp_offs[8];
    int           rem[W];

    exp_offs = '{0, 10, 13, 16, 19, 22, 25, 28};

    rst = 1'b1;
    raw = '0;
    tick(3);
    rst = 1'b0;
    check_all_zero("reset_state");
    tick(2);

    // Single press on channel 0: six cycles from raw edge to clean press.
    raw = 4'b0001;
    tick(5);
    check("p0_early_press", a_press, 4'b0000);
    tick(1);
    check("p0_press",  a_press, 4'b0001);
    check("p0_repeat", a_rep,   4'b0001);
    check("p0_deb",    a_deb,   4'b0001);
    check("p0_al_press", b_press, 4'b0001);
    tick(1);
    check("p0_press_gone", a_press, 4'b0000);
    raw = '0;
    tick(12);

    // Three-cycle glitch on channel 1 must leave it untouched.
    acc = '0;
    raw = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      acc |= a_deb | a_press | a_rel | a_rep;
    end
    raw = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      acc |= a_deb | a_press | a_rel | a_rep;
    end
    check("glitch_ch1", acc[1], 1'b0);

    // Held channel 2: repeat offsets relative to the press pulse.
    raw = 4'b0100;
    tick(6);
    noffs = 0;
    for (int o = 0; o <= 30; o++) begin
      if (a_rep[2]) offs.push_back(o);
      if (n_rep[2]) noffs++;
      tick(1);
    end
    check("rep_count", offs.size(), 8);
    for (int i = 0; i < 8 && i < offs.size(); i++)
      check($sformatf("rep_offset_%0d", i), offs[i], exp_offs[i]);
    check("norep_count", noffs, 1);
    raw = '0;
    tick(12);

    // Channel 3 released so the release lands on a due repeat (offset 13).
    raw = 4'b1000;
    tick(6);
    check("rel_press", a_press, 4'b1000);
    tick(7);
    raw = '0;
    tick(6);
    check("rel_pulse",  a_rel, 4'b1000);
    check("rel_no_rep", a_rep, 4'b0000);
    check("rel_deb",    a_deb, 4'b0000);
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      acc |= a_rep;
    end
    check("rel_idle_no_rep", acc, 4'b0000);

    // Reset in the middle of the repeat delay, button still held.
    raw = 4'b0001;
    tick(6);
    check("rst_pre_press_al", b_press, 4'b0001);
    tick(3);
    check("rst_pre_deb", a_deb, 4'b0001);
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    tick(2);
    rst = 1'b0;
    tick(5);
    check("rst_early_press", a_press, 4'b0000);
    tick(1);
    check("rst_press_a", a_press, 4'b0001);
    check("rst_press_b", b_press, 4'b0001);
    raw = '0;
    tick(12);

    // All channels pressed together.
    raw = 4'hF;
    tick(5);
    check("all_early", a_press, 4'h0);
    tick(1);
    check("all_press", a_press, 4'hF);
    check("all_rep",   a_rep,   4'hF);
    tick(1);
    check("all_after", a_press, 4'h0);
    raw = '0;
    tick(12);

    // Randomised phase: independent per-channel run lengths, occasional reset.
    for (int c = 0; c < W; c++) rem[c] = $urandom_range(1, 8);
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 249) == 0);
      for (int c = 0; c < W; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          raw[c] = ~raw[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40)
                                               : $urandom_range(1, 6);
        end
      end
    end
    rst = 1'b0;
    raw = '0;
    tick(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_button_conditioner
